bldc_pwm_commutator: RTL and testbench

Parametrised three-phase BLDC gate driver. It combines a prescaled PWM generator, a Hall-sensor synchroniser and glitch filter, six-step commutation with direction control, a per-phase dead-time state machine, braking and an invalid-Hall fault. It sits between the speed/duty controller and the six gate-driver pins. It replaces the fixed 8-bit, combinational-commutation PWM driver.

---
 rtl/bldc_pwm_commutator.sv | 130 +++++++++++++
 tb/tb_bldc_pwm_commutator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bldc_pwm_commutator.sv
// bldc_pwm_commutator: three-phase BLDC gate driver with prescaled PWM, filtered Hall
// commutation, direction control, braking, invalid-Hall fault and per-phase dead time.
module bldc_pwm_commutator #(
    parameter int DUTY_W    = 8,
    parameter int PRESC_W   = 16,
    parameter int DEAD_W    = 4,
    parameter int HALL_FILT = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic [DUTY_W-1:0]  DUTY,
    input  logic [PRESC_W-1:0] PRESC,
    input  logic [DEAD_W-1:0]  DEAD,
    input  logic               DIR,
    input  logic               BRAKE,
    input  logic [2:0]         H,
    output logic [2:0]         HI,
    output logic [2:0]         LO,
    output logic               FAULT
);
    localparam int FW = $clog2(HALL_FILT + 1);
    typedef enum logic [1:0] {R_FLOAT, R_HI, R_LO} req_t;
    typedef enum logic [1:0] {S_OFF, S_DEAD, S_HI, S_LO} state_t;

    logic [PRESC_W-1:0] presc_cnt;
    logic [DUTY_W-1:0]  pwm_cnt, shadow;
    logic               tick, pwm_on;
    assign tick   = presc_cnt == PRESC;
    assign pwm_on = pwm_cnt < shadow;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            shadow    <= '0;
        end else if (!EN) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
            if (tick && &pwm_cnt) shadow <= DUTY;
        end
    end

    logic [2:0]    sync1, sync2, hall;
    logic [FW-1:0] filt_cnt;
    logic          hall_valid, accept, hall_bad;
    // a code is accepted once the synchroniser stages have agreed for HALL_FILT cycles
    assign accept   = sync1 == sync2 && filt_cnt == FW'(HALL_FILT - 1);
    assign hall_bad = ~|sync2 || &sync2;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1      <= '0;
            sync2      <= '0;
            filt_cnt   <= '0;
            hall       <= '0;
            hall_valid <= 1'b0;
            FAULT      <= 1'b0;
        end else begin
            sync1    <= H;
            sync2    <= sync1;
            filt_cnt <= sync1 != sync2 ? '0 : accept ? filt_cnt : filt_cnt + 1'b1;
            if (accept && !hall_bad) begin
                hall       <= sync2;
                hall_valid <= 1'b1;
            end
            FAULT <= EN && (FAULT || (accept && hall_bad));
        end
    end

    logic [1:0] hp, lp, hs, ls;
    always_comb begin
        case (hall)
            3'b101:  {hp, lp} = 4'b00_01;
            3'b100:  {hp, lp} = 4'b00_10;
            3'b110:  {hp, lp} = 4'b01_10;
            3'b010:  {hp, lp} = 4'b01_00;
            3'b011:  {hp, lp} = 4'b10_00;
            3'b001:  {hp, lp} = 4'b10_01;
            default: {hp, lp} = 4'b11_11;
        endcase
    end
    assign hs = DIR ? lp : hp;
    assign ls = DIR ? hp : lp;

    req_t req [3];
    for (genvar i = 0; i < 3; i++) begin : g_phase
        state_t            st;
        req_t              tgt, cur;
        logic [DEAD_W-1:0] dcnt;
        logic              hi_q, lo_q;
        assign req[i] = !EN || FAULT || !hall_valid ? R_FLOAT :
                        BRAKE ? R_LO :
                        ls == 2'(i) ? R_LO :
                        hs == 2'(i) && pwm_on ? R_HI : R_FLOAT;
        assign cur = st == S_HI ? R_HI : st == S_LO ? R_LO : R_FLOAT;
        assign HI[i] = hi_q;
        assign LO[i] = lo_q;
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                st   <= S_OFF;
                tgt  <= R_FLOAT;
                dcnt <= '0;
                hi_q <= 1'b0;
                lo_q <= 1'b0;
            end else if (st == S_DEAD) begin
                if (req[i] != tgt) begin
                    tgt  <= req[i];
                    dcnt <= DEAD;
                end else if (dcnt != '0) begin
                    dcnt <= dcnt - 1'b1;
                end else begin
                    st   <= tgt == R_HI ? S_HI : tgt == R_LO ? S_LO : S_OFF;
                    hi_q <= tgt == R_HI;
                    lo_q <= tgt == R_LO;
                end
            end else if (req[i] != cur) begin
                // turning off is immediate; turning anything on goes through dead time
                st   <= req[i] == R_FLOAT ? S_OFF : S_DEAD;
                tgt  <= req[i];
                dcnt <= DEAD;
                hi_q <= 1'b0;
                lo_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bldc_pwm_commutator.sv
// tb_bldc_pwm_commutator: directed and random stimulus against a cycle-level reference model.
module tb_bldc_pwm_commutator;
    localparam int HF = 3;
    logic        CLK = 0, RST = 0, EN = 0, DIR = 0, BRAKE = 0;
    logic [7:0]  DUTY = 0;
    logic [15:0] PRESC = 0;
    logic [3:0]  DEAD = 0;
    logic [2:0]  H = 0;
    logic [2:0]  HI, LO;
    logic        FAULT;
    int checks = 0, errors = 0;

    logic [2:0] hq[$];
    int         n, shadow, run_hi[3], run_lo[3];
    logic       mf, mv;
    logic [2:0] mh;

    bldc_pwm_commutator #(.DUTY_W(8), .PRESC_W(16), .DEAD_W(4), .HALL_FILT(HF)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .DUTY(DUTY), .PRESC(PRESC), .DEAD(DEAD),
        .DIR(DIR), .BRAKE(BRAKE), .H(H), .HI(HI), .LO(LO), .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void sector(input logic [2:0] c, input logic d, output int hp, output int lp);
        int t;
        case (c)
            3'b101:  begin hp = 0; lp = 1; end
            3'b100:  begin hp = 0; lp = 2; end
            3'b110:  begin hp = 1; lp = 2; end
            3'b010:  begin hp = 1; lp = 0; end
            3'b011:  begin hp = 2; lp = 0; end
            3'b001:  begin hp = 2; lp = 1; end
            default: begin hp = -1; lp = -1; end
        endcase
        if (d) begin t = hp; hp = lp; lp = t; end
    endfunction

    // 0 = float, 1 = high side, 2 = low side
    function automatic int req_of(input int p);
        int hp, lp;
        bit on;
        if (!EN || mf || !mv) return 0;
        if (BRAKE) return 2;
        sector(mh, DIR, hp, lp);
        on = ((n / (int'(PRESC) + 1)) % 256) < shadow;
        return p == lp ? 2 : (p == hp && on) ? 1 : 0;
    endfunction

    task automatic model_reset();
        hq.delete();
        hq.push_back(3'b000);
        hq.push_back(3'b000);
        n = 0; shadow = 0; mf = 0; mv = 0; mh = 0;
        for (int p = 0; p < 3; p++) begin run_hi[p] = 0; run_lo[p] = 0; end
    endtask

    task automatic model_edge();
        int per, r;
        bit acc;
        per = (int'(PRESC) + 1) * 256;
        for (int p = 0; p < 3; p++) begin
            r = req_of(p);
            run_hi[p] = r == 1 ? run_hi[p] + 1 : 0;
            run_lo[p] = r == 2 ? run_lo[p] + 1 : 0;
        end
        acc = hq.size() == HF + 1;
        foreach (hq[k]) if (hq[k] != hq[0]) acc = 0;
        mf = EN && (mf || (acc && (hq[HF] == 3'b000 || hq[HF] == 3'b111)));
        if (acc && hq[HF] != 3'b000 && hq[HF] != 3'b111) begin mv = 1; mh = hq[HF]; end
        if (EN) begin
            if ((n + 1) % per == 0) shadow = DUTY;
            n = (n + 1) % per;
        end else n = 0;
        hq.push_back(H);
        if (hq.size() > HF + 1) void'(hq.pop_front());
    endtask

    // a gate is on exactly when it has been requested for the last DEAD+2 sampled cycles
    task automatic cyc(input int k);
        logic [2:0] eh, el;
        repeat (k) begin
            @(posedge CLK);
            model_edge();
            #1;
            for (int p = 0; p < 3; p++) begin
                eh[p] = run_hi[p] >= int'(DEAD) + 2;
                el[p] = run_lo[p] >= int'(DEAD) + 2;
            end
            chk("hi", HI, eh);
            chk("lo", LO, el);
            chk("fault", FAULT, mf);
            chk("excl", HI & LO, 0);
        end
    endtask

    task automatic do_reset();
        #2 RST = 0;
        #1;
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_fault", FAULT, 0);
        model_reset();
        #2 RST = 1;
    endtask

    task automatic settle_change(input int presc, input int dead);
        EN = 0;
        cyc(8);
        PRESC = 16'(presc);
        DEAD = 4'(dead);
        cyc(1);
        EN = 1;
    endtask

    initial begin
        logic [2:0] codes [6];
        logic [2:0] ev;
        int hp, lp, r;
        codes = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
        EN = 1; DUTY = 128; PRESC = 0; DEAD = 3; H = 3'b101;
        #1;
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_fault", FAULT, 0);
        model_reset();
        #1 RST = 1;
        cyc(800);
        chk("lo_b", LO, 3'b010);

        for (int d = 0; d < 2; d++) begin
            DIR = d[0];
            foreach (codes[c]) begin
                H = codes[c];
                cyc(30);
                sector(codes[c], DIR, hp, lp);
                ev = 3'b001 << lp;
                chk("sect_lo", LO, ev);
            end
        end

        DIR = 0; H = 3'b101;
        cyc(30);
        H = 3'b100;
        cyc(2);
        H = 3'b101;
        cyc(20);
        chk("glitch_lo", LO, 3'b010);
        H = 3'b100;
        cyc(15);
        chk("accept_lo", LO, 3'b100);

        H = 3'b111;
        cyc(10);
        chk("fault_set", FAULT, 1);
        chk("fault_hi", HI, 0);
        chk("fault_lo", LO, 0);
        H = 3'b101;
        cyc(10);
        chk("fault_sticky", FAULT, 1);
        EN = 0;
        cyc(1);
        chk("fault_clr", FAULT, 0);
        EN = 1;

        cyc(300);
        BRAKE = 1;
        cyc(1);
        chk("brake_hi", HI, 0);
        cyc(int'(DEAD) + 1);
        chk("brake_lo", LO, 3'b111);
        BRAKE = 0; DUTY = 0;
        cyc(600);
        chk("duty0_hi", HI, 0);
        DUTY = 255;
        cyc(600);

        repeat (150) begin
            r = $urandom_range(0, 9);
            if (r == 0) settle_change($urandom_range(0, 3), $urandom_range(0, 4));
            else begin
                H = r < 9 ? codes[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) DUTY = 8'($urandom);
                DIR = 1'($urandom_range(0, 1));
                BRAKE = $urandom_range(0, 7) == 0;
                cyc($urandom_range(1, 25));
            end
        end

        BRAKE = 0; DIR = 0;
        settle_change(0, 4);
        H = 3'b101;
        cyc(30);
        H = 3'b100;
        cyc(7);
        do_reset();
        cyc(4);
        chk("post_rst_hi", HI, 0);
        chk("post_rst_lo", LO, 0);
        cyc(20);
        chk("post_rst_lo2", LO, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
